ddr4_reg_master: RTL and testbench
==================================

Name: ddr4_reg_master

Overview:
- Initiator for the TCU-style register interface (config_en/wben/addr/wdata/rdata) used by the DDR4 status regfile and other units.
- Takes single commands over a valid/ready port, drives one register access on the bus, and returns a response over a second valid/ready port.
- Commands are read, write, or poll. Poll repeatedly reads an address until a masked compare matches or an attempt budget runs out.
- Used by the DDR4 bring-up sequencer, for example to wait on calibration-complete before releasing traffic.

Parameters:
- TCU_REG_ADDR_SIZE, 32, register address width
- TCU_REG_DATA_SIZE, 64, register data width
- TCU_REG_BSEL_SIZE, 8, byte-enable width (TCU_REG_DATA_SIZE/8)
- POLL_CNT_SIZE, 16, width of the poll attempt counter
- POLL_GAP, 4, idle cycles between poll reads (minimum 1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  00 read, 01 write, 10 poll, 11 reserved
- cmd_addr_i  in  TCU_REG_ADDR_SIZE  register address
- cmd_wdata_i  in  TCU_REG_DATA_SIZE  write data (write) / compare value (poll)
- cmd_bsel_i  in  TCU_REG_BSEL_SIZE  byte enables (write only)
- cmd_mask_i  in  TCU_REG_DATA_SIZE  compare mask (poll only)
- cmd_poll_cnt_i  in  POLL_CNT_SIZE  max poll attempts; 0 is treated as 1
- config_en_o  out  1  bus access strobe
- config_wben_o  out  TCU_REG_BSEL_SIZE  byte enables; all-zero means read
- config_addr_o  out  TCU_REG_ADDR_SIZE  bus address
- config_wdata_o  out  TCU_REG_DATA_SIZE  bus write data
- config_rdata_i  in  TCU_REG_DATA_SIZE  read data, valid the cycle after the read strobe
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  TCU_REG_DATA_SIZE  read data / last polled value; 0 for writes
- rsp_status_o  out  2  00 ok, 01 poll timeout, 10 error

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: config_en_o=0, config_wben_o=0, config_addr_o=0, config_wdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_status_o=00. cmd_ready_o=1 after reset.
  - Any in-flight command is abandoned and produces no response.
- All outputs are registered. States are IDLE, ISSUE, CAPTURE, GAP, RESP.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch all cmd fields. Next state:
  - op 11, or op 01 with cmd_bsel_i=0 -> RESP with status 10; no bus access.
  - Otherwise -> ISSUE.
- ISSUE: exactly one cycle with config_en_o=1 and address/data from the latched command.
  - config_wben_o = bsel for write, 0 for read/poll. config_wdata_o = wdata for write, 0 otherwise.
  - Write -> RESP with status 00, rdata 0.
  - Read/poll -> CAPTURE.
- config_en_o is never high for two consecutive cycles.
- CAPTURE: sample config_rdata_i into rsp_rdata_o (one cycle after the strobe).
  - Read -> RESP with status 00.
  - Poll: attempt counter is loaded with max(cmd_poll_cnt_i,1) at accept and decremented per capture.
    - If (rdata & mask) == (wdata & mask) -> RESP, status 00.
    - Else if the decremented count is 0 -> RESP, status 01, rsp_rdata_o = last sample.
    - Else -> GAP.
- GAP: wait POLL_GAP cycles using a down-counter, then -> ISSUE.
- RESP: rsp_valid_o=1 and rsp_* held stable until rsp_ready_i. The handshake cycle -> IDLE.
  - The next command can be accepted the cycle after the handshake.
  - cmd_ready_o=0 in all states except IDLE.
- Latencies from accept to rsp_valid_o:
  - Write: 2 cycles.
  - Read: 3 cycles.
  - Poll matching on attempt k: 3 + (k-1)*(POLL_GAP+2) cycles.
- A mask of all-zero on poll matches on the first read.
- Counters saturate at 0 and never wrap.
- Inputs cmd_* are ignored while not in IDLE.

Test Plan:
- Reset, then read addr 0x8 with the responder returning 0x1 -> one strobe with wben=0, addr 0x8; rsp after 3 cycles with rdata=0x1, status 00.
- Write addr 0x10, wdata 0xDEADBEEF, bsel 0x0F -> single strobe with wben=0x0F, wdata 0xDEADBEEF; rsp after 2 cycles with rdata=0, status 00.
- Poll addr 0x8, mask 0x1, value 0x1, cnt 5, with the responder returning 0,0,1 -> 3 strobes spaced POLL_GAP+2 cycles apart; status 00, rdata=0x1.
- Poll with cnt 3 and the value never matching -> exactly 3 strobes; status 01, last sample returned. Repeat with cnt 0 -> exactly 1 strobe, status 01.
- Write with bsel=0, and op 11 -> no strobe at all, status 10. Hold rsp_ready_i low 10 cycles -> rsp fields stable and cmd_ready_o low throughout.
- Assert reset during GAP of a poll -> all outputs zero immediately and no response. A new read after release completes normally.

Source files
------------

// File: rtl/ddr4_reg_master_if.sv
// Bundles the command, register-bus and response channels of the
// DDR4 register master. The master modport is the initiator's view;
// the slave modport is the view of whoever drives commands, answers
// register reads and consumes responses.
interface ddr4_reg_master_if #(
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_DATA_SIZE = 64,
  parameter int TCU_REG_BSEL_SIZE = 8,
  parameter int POLL_CNT_SIZE     = 16
);
  // command channel
  logic                         cmd_valid_i;
  logic                         cmd_ready_o;
  logic [1:0]                   cmd_op_i;
  logic [TCU_REG_ADDR_SIZE-1:0] cmd_addr_i;
  logic [TCU_REG_DATA_SIZE-1:0] cmd_wdata_i;
  logic [TCU_REG_BSEL_SIZE-1:0] cmd_bsel_i;
  logic [TCU_REG_DATA_SIZE-1:0] cmd_mask_i;
  logic [POLL_CNT_SIZE-1:0]     cmd_poll_cnt_i;

  // register bus
  logic                         config_en_o;
  logic [TCU_REG_BSEL_SIZE-1:0] config_wben_o;
  logic [TCU_REG_ADDR_SIZE-1:0] config_addr_o;
  logic [TCU_REG_DATA_SIZE-1:0] config_wdata_o;
  logic [TCU_REG_DATA_SIZE-1:0] config_rdata_i;

  // response channel
  logic                         rsp_valid_o;
  logic                         rsp_ready_i;
  logic [TCU_REG_DATA_SIZE-1:0] rsp_rdata_o;
  logic [1:0]                   rsp_status_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i, cmd_bsel_i,
           cmd_mask_i, cmd_poll_cnt_i, config_rdata_i, rsp_ready_i,
    output cmd_ready_o, config_en_o, config_wben_o, config_addr_o,
           config_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_status_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_wdata_i, cmd_bsel_i,
           cmd_mask_i, cmd_poll_cnt_i, config_rdata_i, rsp_ready_i,
    input  cmd_ready_o, config_en_o, config_wben_o, config_addr_o,
           config_wdata_o, rsp_valid_o, rsp_rdata_o, rsp_status_o
  );
endinterface

// File: rtl/ddr4_reg_master.sv
// Register-bus initiator: accepts one read/write/poll command at a time,
// performs the bus access(es) and returns a single response. Poll keeps
// re-reading an address, POLL_GAP idle cycles apart, until the masked
// value matches or the attempt budget is spent. Every output is a flop.
module ddr4_reg_master #(
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_DATA_SIZE = 64,
  parameter int TCU_REG_BSEL_SIZE = 8,
  parameter int POLL_CNT_SIZE     = 16,
  parameter int POLL_GAP          = 4
) (
  input logic               clk_i,
  input logic               reset_i,
  ddr4_reg_master_if.master bus
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ERROR   = 2'b10;

  logic [2:0]                   state;
  logic [1:0]                   op_q;
  logic [TCU_REG_DATA_SIZE-1:0] wdata_q;
  logic [TCU_REG_DATA_SIZE-1:0] mask_q;
  logic [POLL_CNT_SIZE-1:0]     poll_cnt_q;
  logic [GAP_W-1:0]             gap_cnt_q;

  logic                         cmd_bad;
  logic                         poll_hit;
  logic [POLL_CNT_SIZE-1:0]     poll_cnt_dec;

  // Decode of the incoming command, the poll compare against the live
  // bus data, and the saturating attempt decrement.
  always_comb begin
    cmd_bad      = (bus.cmd_op_i == 2'b11) ||
                   ((bus.cmd_op_i == OP_WRITE) && (bus.cmd_bsel_i == '0));
    poll_hit     = ((bus.config_rdata_i ^ wdata_q) & mask_q) == '0;
    poll_cnt_dec = (poll_cnt_q != '0) ? poll_cnt_q - 1'b1 : '0;
  end

  // Main sequencer: outputs are loaded on the edge that enters the state
  // they belong to, so the strobe and response appear as clean flops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state              <= S_IDLE;
      op_q               <= OP_READ;
      wdata_q            <= '0;
      mask_q             <= '0;
      poll_cnt_q         <= '0;
      gap_cnt_q          <= '0;
      bus.cmd_ready_o    <= 1'b1;
      bus.config_en_o    <= 1'b0;
      bus.config_wben_o  <= '0;
      bus.config_addr_o  <= '0;
      bus.config_wdata_o <= '0;
      bus.rsp_valid_o    <= 1'b0;
      bus.rsp_rdata_o    <= '0;
      bus.rsp_status_o   <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            op_q            <= bus.cmd_op_i;
            wdata_q         <= bus.cmd_wdata_i;
            mask_q          <= bus.cmd_mask_i;
            poll_cnt_q      <= (bus.cmd_poll_cnt_i == '0) ?
                               POLL_CNT_SIZE'(1) : bus.cmd_poll_cnt_i;
            bus.cmd_ready_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            if (cmd_bad) begin
              state            <= S_RESP;
              bus.rsp_valid_o  <= 1'b1;
              bus.rsp_status_o <= ST_ERROR;
            end else begin
              state              <= S_ISSUE;
              bus.config_en_o    <= 1'b1;
              bus.config_addr_o  <= bus.cmd_addr_i;
              bus.config_wben_o  <= (bus.cmd_op_i == OP_WRITE) ? bus.cmd_bsel_i : '0;
              bus.config_wdata_o <= (bus.cmd_op_i == OP_WRITE) ? bus.cmd_wdata_i : '0;
            end
          end
        end

        S_ISSUE: begin
          bus.config_en_o   <= 1'b0;
          bus.config_wben_o <= '0;
          if (op_q == OP_WRITE) begin
            state            <= S_RESP;
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_status_o <= ST_OK;
          end else begin
            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          bus.rsp_rdata_o <= bus.config_rdata_i;
          if ((op_q == OP_POLL) && !poll_hit) begin
            poll_cnt_q <= poll_cnt_dec;
            if (poll_cnt_dec == '0) begin
              state            <= S_RESP;
              bus.rsp_valid_o  <= 1'b1;
              bus.rsp_status_o <= ST_TIMEOUT;
            end else begin
              state     <= S_GAP;
              gap_cnt_q <= GAP_W'(POLL_GAP);
            end
          end else begin
            state            <= S_RESP;
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_status_o <= ST_OK;
          end
        end

        S_GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            state           <= S_ISSUE;
            gap_cnt_q       <= '0;
            bus.config_en_o <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready_i) begin
            state           <= S_IDLE;
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
          end
        end

        default: begin
          state           <= S_IDLE;
          bus.cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_reg_master.sv
// Directed bench for ddr4_reg_master: drives commands, models the register
// responder with a queue of read values, and checks strobes, latencies and
// responses against hand-computed values.
module tb_ddr4_reg_master;

  localparam int POLL_GAP = 4;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  ddr4_reg_master_if bus_if ();

  ddr4_reg_master #(
    .TCU_REG_ADDR_SIZE(32),
    .TCU_REG_DATA_SIZE(64),
    .TCU_REG_BSEL_SIZE(8),
    .POLL_CNT_SIZE(16),
    .POLL_GAP(POLL_GAP)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc        = 0;
  int          strobe_cnt = 0;
  int          prev_stamp = 0;
  int          last_stamp = 0;
  logic        prev_en    = 1'b0;
  logic        double_en  = 1'b0;
  logic [7:0]  last_wben  = '0;
  logic [31:0] last_addr  = '0;
  logic [63:0] last_wdata = '0;

  logic [63:0] resp_q[$];
  logic [63:0] resp_default = 64'hA5A0;
  logic [63:0] resp_next;

  // free-running clock
  always #5 clk_i = ~clk_i;

  // bus monitor: counts strobes, timestamps them and flags back-to-back strobes
  always @(posedge clk_i) begin
    cyc     <= cyc + 1;
    prev_en <= bus_if.config_en_o;
    if (bus_if.config_en_o) begin
      strobe_cnt <= strobe_cnt + 1;
      prev_stamp <= last_stamp;
      last_stamp <= cyc;
      last_wben  <= bus_if.config_wben_o;
      last_addr  <= bus_if.config_addr_o;
      last_wdata <= bus_if.config_wdata_o;
      if (prev_en) double_en <= 1'b1;
    end
  end

  // register responder: read data appears the cycle after a read strobe
  always @(posedge clk_i) begin
    if (bus_if.config_en_o && (bus_if.config_wben_o == '0)) begin
      if (resp_q.size() != 0) resp_next = resp_q.pop_front();
      else resp_next = resp_default;
      bus_if.config_rdata_i <= resp_next;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic [7:0] bsel,
                                input logic [63:0] mask, input logic [15:0] cnt,
                                output int base);
    @(negedge clk_i);
    check_output("cmd_ready_idle", bus_if.cmd_ready_o, 1'b1);
    bus_if.cmd_op_i       = op;
    bus_if.cmd_addr_i     = addr;
    bus_if.cmd_wdata_i    = wdata;
    bus_if.cmd_bsel_i     = bsel;
    bus_if.cmd_mask_i     = mask;
    bus_if.cmd_poll_cnt_i = cnt;
    bus_if.cmd_valid_i    = 1'b1;
    base = strobe_cnt;
    @(posedge clk_i);
    #1 bus_if.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk_i);
      lat++;
      if (bus_if.rsp_valid_o) break;
    end
    check_output("rsp_valid_seen", bus_if.rsp_valid_o, 1'b1);
  endtask

  task automatic finish_rsp();
    bus_if.rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 bus_if.rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check_output("rsp_valid_drop", bus_if.rsp_valid_o, 1'b0);
    check_output("cmd_ready_back", bus_if.cmd_ready_o, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_en"},     bus_if.config_en_o, 1'b0);
    check_output({tag, "_wben"},   bus_if.config_wben_o, 8'h0);
    check_output({tag, "_addr"},   bus_if.config_addr_o, 32'h0);
    check_output({tag, "_wdata"},  bus_if.config_wdata_o, 64'h0);
    check_output({tag, "_rvalid"}, bus_if.rsp_valid_o, 1'b0);
    check_output({tag, "_rdata"},  bus_if.rsp_rdata_o, 64'h0);
    check_output({tag, "_status"}, bus_if.rsp_status_o, 2'b00);
    check_output({tag, "_ready"},  bus_if.cmd_ready_o, 1'b1);
  endtask

  initial begin
    int   base;
    int   lat;
    logic seen_valid;

    bus_if.cmd_valid_i    = 1'b0;
    bus_if.cmd_op_i       = 2'b00;
    bus_if.cmd_addr_i     = '0;
    bus_if.cmd_wdata_i    = '0;
    bus_if.cmd_bsel_i     = '0;
    bus_if.cmd_mask_i     = '0;
    bus_if.cmd_poll_cnt_i = '0;
    bus_if.config_rdata_i = '0;
    bus_if.rsp_ready_i    = 1'b0;

    $display("[TB] reset");
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    reset_i = 1'b0;

    $display("[TB] read 0x8");
    resp_q.push_back(64'h1);
    apply_stimulus(2'b00, 32'h8, 64'h0, 8'h0, 64'h0, 16'd0, base);
    wait_rsp(lat);
    check_output("rd_latency", lat, 3);
    check_output("rd_strobes", strobe_cnt - base, 1);
    check_output("rd_wben", last_wben, 8'h0);
    check_output("rd_addr", last_addr, 32'h8);
    check_output("rd_rdata", bus_if.rsp_rdata_o, 64'h1);
    check_output("rd_status", bus_if.rsp_status_o, 2'b00);
    finish_rsp();

    $display("[TB] write 0x10");
    apply_stimulus(2'b01, 32'h10, 64'hDEADBEEF, 8'h0F, 64'h0, 16'd0, base);
    wait_rsp(lat);
    check_output("wr_latency", lat, 2);
    check_output("wr_strobes", strobe_cnt - base, 1);
    check_output("wr_wben", last_wben, 8'h0F);
    check_output("wr_addr", last_addr, 32'h10);
    check_output("wr_wdata", last_wdata, 64'hDEADBEEF);
    check_output("wr_rdata", bus_if.rsp_rdata_o, 64'h0);
    check_output("wr_status", bus_if.rsp_status_o, 2'b00);
    finish_rsp();

    $display("[TB] poll matching on third attempt");
    resp_q.push_back(64'h0);
    resp_q.push_back(64'h0);
    resp_q.push_back(64'h1);
    apply_stimulus(2'b10, 32'h8, 64'h1, 8'h0, 64'h1, 16'd5, base);
    wait_rsp(lat);
    check_output("poll_latency", lat, 3 + 2 * (POLL_GAP + 2));
    check_output("poll_strobes", strobe_cnt - base, 3);
    check_output("poll_spacing", last_stamp - prev_stamp, POLL_GAP + 2);
    check_output("poll_wben", last_wben, 8'h0);
    check_output("poll_wdata", last_wdata, 64'h0);
    check_output("poll_rdata", bus_if.rsp_rdata_o, 64'h1);
    check_output("poll_status", bus_if.rsp_status_o, 2'b00);
    finish_rsp();

    $display("[TB] poll timeout cnt 3");
    resp_q.push_back(64'h10);
    resp_q.push_back(64'h20);
    resp_q.push_back(64'h30);
    apply_stimulus(2'b10, 32'h8, 64'h1, 8'h0, 64'h1, 16'd3, base);
    wait_rsp(lat);
    check_output("tmo3_latency", lat, 3 + 2 * (POLL_GAP + 2));
    check_output("tmo3_strobes", strobe_cnt - base, 3);
    check_output("tmo3_rdata", bus_if.rsp_rdata_o, 64'h30);
    check_output("tmo3_status", bus_if.rsp_status_o, 2'b01);
    finish_rsp();

    $display("[TB] poll timeout cnt 0");
    resp_q.push_back(64'h44);
    apply_stimulus(2'b10, 32'h8, 64'h1, 8'h0, 64'h1, 16'd0, base);
    wait_rsp(lat);
    check_output("tmo0_latency", lat, 3);
    check_output("tmo0_strobes", strobe_cnt - base, 1);
    check_output("tmo0_rdata", bus_if.rsp_rdata_o, 64'h44);
    check_output("tmo0_status", bus_if.rsp_status_o, 2'b01);
    finish_rsp();

    $display("[TB] poll with zero mask");
    resp_q.push_back(64'h1234);
    apply_stimulus(2'b10, 32'h8, 64'hFF, 8'h0, 64'h0, 16'd4, base);
    wait_rsp(lat);
    check_output("mask0_latency", lat, 3);
    check_output("mask0_strobes", strobe_cnt - base, 1);
    check_output("mask0_rdata", bus_if.rsp_rdata_o, 64'h1234);
    check_output("mask0_status", bus_if.rsp_status_o, 2'b00);
    finish_rsp();

    $display("[TB] write with zero byte enables");
    apply_stimulus(2'b01, 32'h18, 64'h55, 8'h00, 64'h0, 16'd0, base);
    wait_rsp(lat);
    check_output("bsel0_latency", lat, 1);
    check_output("bsel0_status", bus_if.rsp_status_o, 2'b10);
    check_output("bsel0_rdata", bus_if.rsp_rdata_o, 64'h0);
    finish_rsp();
    check_output("bsel0_strobes", strobe_cnt - base, 0);

    $display("[TB] reserved op with response held");
    apply_stimulus(2'b11, 32'h30, 64'h77, 8'hFF, 64'h0, 16'd0, base);
    wait_rsp(lat);
    check_output("op3_latency", lat, 1);
    bus_if.cmd_op_i    = 2'b00;
    bus_if.cmd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_output("hold_valid", bus_if.rsp_valid_o, 1'b1);
      check_output("hold_status", bus_if.rsp_status_o, 2'b10);
      check_output("hold_rdata", bus_if.rsp_rdata_o, 64'h0);
      check_output("hold_ready", bus_if.cmd_ready_o, 1'b0);
      @(negedge clk_i);
    end
    bus_if.cmd_valid_i = 1'b0;
    check_output("op3_strobes", strobe_cnt - base, 0);
    finish_rsp();

    $display("[TB] reset during poll gap");
    apply_stimulus(2'b10, 32'h40, 64'h1, 8'h0, 64'h1, 16'd5, base);
    repeat (4) @(negedge clk_i);
    check_output("gap_strobes", strobe_cnt - base, 1);
    #2 reset_i = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    base = strobe_cnt;
    seen_valid = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      if (bus_if.rsp_valid_o) seen_valid = 1'b1;
    end
    check_output("abandon_no_rsp", seen_valid, 1'b0);
    check_output("abandon_no_strobe", strobe_cnt - base, 0);

    $display("[TB] read after reset");
    resp_q.push_back(64'hCAFE);
    apply_stimulus(2'b00, 32'h20, 64'h0, 8'h0, 64'h0, 16'd0, base);
    wait_rsp(lat);
    check_output("rd2_latency", lat, 3);
    check_output("rd2_strobes", strobe_cnt - base, 1);
    check_output("rd2_addr", last_addr, 32'h20);
    check_output("rd2_rdata", bus_if.rsp_rdata_o, 64'hCAFE);
    check_output("rd2_status", bus_if.rsp_status_o, 2'b00);
    finish_rsp();

    check_output("no_double_strobe", double_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
